// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl: instruction fetch sequencer with a debug read port.
// Fetches 16-bit words, halts on HALT_OPCODE and grants bounded-wait debug reads.
module prog_fetch_ctrl #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] HALT_OPCODE  = 16'hFFFF,
    parameter int          DBG_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [15:0] branch_addr,
    input  logic        dbg_req,
    input  logic [15:0] dbg_addr,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic        dbg_ack,
    output logic [15:0] dbg_data,
    output logic        halted
);

    localparam int WW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(DBG_MAX_WAIT);
    localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DBG,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic [15:0]   dbg_data_q, dbg_data_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [WW-1:0] dbg_wait_q, dbg_wait_d;
    logic          pend_q, pend_d;
    logic [15:0]   pend_addr_q, pend_addr_d;

    logic [15:0]   fetch_addr;
    logic          br_any;
    logic [15:0]   br_tgt;
    logic          grant;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            pc_q          <= PC_INIT;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            dbg_data_q    <= 16'h0000;
            dbg_ack_q     <= 1'b0;
            dbg_wait_q    <= '0;
            pend_q        <= 1'b0;
            pend_addr_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            dbg_data_q    <= dbg_data_d;
            dbg_ack_q     <= dbg_ack_d;
            dbg_wait_q    <= dbg_wait_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
        end
    end

    // Branch source and debug grant decision for the FETCH state
    always_comb begin
        fetch_addr = {pc_q[15:1], 1'b0};
        br_any     = branch_en | pend_q;
        br_tgt     = branch_en ? branch_addr : pend_addr_q;
        // A fresh ack blocks the next grant so acks never touch
        grant      = dbg_req && !dbg_ack_q && !br_any &&
                     (stall || (dbg_wait_q == WAIT_MAX));
    end

    // Next-state, datapath updates and memory address selection
    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        dbg_data_d    = dbg_data_q;
        dbg_ack_d     = 1'b0;
        dbg_wait_d    = '0;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        mem_addr      = fetch_addr;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_INIT;
                end else if (dbg_req && !dbg_ack_q) begin
                    state_d = S_DBG;
                    ret_d   = S_IDLE;
                end
            end
            S_FETCH: begin
                pend_d = 1'b0;
                if (dbg_req && !grant && (dbg_wait_q != WAIT_MAX))
                    dbg_wait_d = dbg_wait_q + WW'(1);
                else if (dbg_req && !grant)
                    dbg_wait_d = dbg_wait_q;
                if (br_any) begin
                    pc_d = br_tgt & 16'hFFFE;
                end else if (grant) begin
                    state_d = S_DBG;
                    ret_d   = S_FETCH;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (mem_data == HALT_OPCODE) begin
                    instr_d       = HALT_OPCODE;
                    instr_valid_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    instr_d       = mem_data;
                    instr_valid_d = 1'b1;
                    pc_d          = fetch_addr + 16'd2;
                end
            end
            S_DBG: begin
                mem_addr   = dbg_addr;
                dbg_data_d = mem_data;
                dbg_ack_d  = 1'b1;
                state_d    = ret_q;
                // Redirects seen while reading are replayed on return
                if (branch_en && (ret_q == S_FETCH)) begin
                    pend_d      = 1'b1;
                    pend_addr_d = branch_addr;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = PC_INIT;
                end else if (dbg_req && !dbg_ack_q) begin
                    state_d = S_DBG;
                    ret_d   = S_HALT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign dbg_ack     = dbg_ack_q;
    assign dbg_data    = dbg_data_q;
    assign halted      = (state_q == S_HALT) ||
                         ((state_q == S_DBG) && (ret_q == S_HALT));

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// tb_prog_fetch_ctrl: directed vectors plus hand sequences
// against a byte-addressed little-endian memory model.
module tb_prog_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_addr = 16'h0;
    logic        dbg_req = 1'b0;
    logic [15:0] dbg_addr = 16'h0;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        dbg_ack;
    logic [15:0] dbg_data;
    logic        halted;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] maddr1;

    assign maddr1   = mem_addr + 16'd1;
    assign mem_data = {mem[maddr1], mem[mem_addr]};

    always #5 clk = ~clk;

    prog_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .dbg_ack(dbg_ack), .dbg_data(dbg_data), .halted(halted)
    );

    typedef struct {
        logic        st;
        logic        stl;
        logic        br;
        logic [15:0] ba;
        logic [15:0] e_pc;
        logic        e_vld;
        logic [15:0] e_ins;
        logic        e_hlt;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [15:0] wrd(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem[b], mem[a]};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string nm, input logic [15:0] e_pc,
                             input logic e_v, input logic [15:0] e_i);
        chk({nm, "_pc"}, pc, e_pc);
        chk({nm, "_vld"}, 16'(instr_valid), 16'(e_v));
        if (e_v) chk({nm, "_ins"}, instr, e_i);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h11; mem[1] = 8'h11;
        mem[2] = 8'h22; mem[3] = 8'h22;
        mem[4] = 8'hFF; mem[5] = 8'hFF;
        mem[16'h10] = 8'h10; mem[16'h11] = 8'h10;
        mem[16'h12] = 8'h12; mem[16'h13] = 8'h12;
        mem[16'h40] = 8'hCD; mem[16'h41] = 8'hAB;

        //            st    stl   br    ba       pc       vld   instr    hlt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0,   16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0,   16'h0002, 1'b1, 16'h1111, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0,   16'h0004, 1'b1, 16'h2222, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0,   16'h0004, 1'b1, 16'hFFFF, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h80,  16'h0004, 1'b0, 16'hFFFF, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0,   16'h0000, 1'b0, 16'hFFFF, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h11,  16'h0010, 1'b0, 16'hFFFF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'h0,   16'h0010, 1'b0, 16'hFFFF, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0,   16'h0010, 1'b0, 16'hFFFF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0,   16'h0010, 1'b0, 16'hFFFF, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0,   16'h0012, 1'b1, 16'h1010, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h41,  16'h0040, 1'b0, 16'h1010, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0,   16'h0042, 1'b1, 16'hABCD, 1'b0};

        // reset state
        #12;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_vld", 16'(instr_valid), 16'h0);
        chk("rst_ins", instr, 16'h0000);
        chk("rst_ack", 16'(dbg_ack), 16'h0);
        chk("rst_hlt", 16'(halted), 16'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("idle_pc", pc, 16'h0000);

        // table: start, fetch to halt, stall, branch-over-stall
        for (int i = 0; i < 13; i++) begin
            start       = tbl[i].st;
            stall       = tbl[i].stl;
            branch_en   = tbl[i].br;
            branch_addr = tbl[i].ba;
            cyc();
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_vld", i), 16'(instr_valid), 16'(tbl[i].e_vld));
            chk($sformatf("v%0d_ins", i), instr, tbl[i].e_ins);
            chk($sformatf("v%0d_hlt", i), 16'(halted), 16'(tbl[i].e_hlt));
            chk($sformatf("v%0d_ack", i), 16'(dbg_ack), 16'h0);
            chk($sformatf("v%0d_ma", i), mem_addr, tbl[i].e_pc);
        end
        start = 1'b0; stall = 1'b0; branch_en = 1'b0;

        // debug read waits exactly four fetch cycles
        dbg_req = 1'b1; dbg_addr = 16'h0033;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_fetch($sformatf("dw%0d", k), 16'h0044 + 16'(2 * k), 1'b1,
                      wrd(16'h0042 + 16'(2 * k)));
            chk($sformatf("dw%0d_ack", k), 16'(dbg_ack), 16'h0);
        end
        cyc();
        chk_fetch("dgrant", 16'h004A, 1'b0, 16'h0);
        chk("dgrant_ma", mem_addr, 16'h0033);
        chk("dgrant_ack", 16'(dbg_ack), 16'h0);
        stall = 1'b1;
        cyc();
        chk("dack", 16'(dbg_ack), 16'h0001);
        chk("ddata", dbg_data, 16'h6E69);
        chk("dack_pc", pc, 16'h004A);
        chk("dack_ma", mem_addr, 16'h004A);
        // held request with stall must not grant right after an ack
        cyc();
        chk("noback_ack", 16'(dbg_ack), 16'h0);
        chk("noback_ma", mem_addr, 16'h004A);
        cyc();
        chk("regrant_ma", mem_addr, 16'h0033);
        chk("regrant_ack", 16'(dbg_ack), 16'h0);
        dbg_req = 1'b0; stall = 1'b0;
        cyc();
        chk("reack", 16'(dbg_ack), 16'h0001);
        cyc();
        chk_fetch("post", 16'h004C, 1'b1, wrd(16'h004A));
        chk("post_ack", 16'(dbg_ack), 16'h0);

        // branch during a debug read is replayed after return
        dbg_req = 1'b1; stall = 1'b1;
        cyc();
        chk("pb_dbg_ma", mem_addr, 16'h0033);
        dbg_req = 1'b0; stall = 1'b0; branch_en = 1'b1; branch_addr = 16'h0021;
        cyc();
        chk("pb_ack", 16'(dbg_ack), 16'h0001);
        chk_fetch("pb_ret", 16'h004C, 1'b0, 16'h0);
        branch_en = 1'b0;
        cyc();
        chk_fetch("pb_apply", 16'h0020, 1'b0, 16'h0);
        cyc();
        chk_fetch("pb_fetch", 16'h0022, 1'b1, wrd(16'h0020));

        // pc wraps from 0xFFFE to 0x0000 without a bubble
        branch_en = 1'b1; branch_addr = 16'hFFFF;
        cyc();
        chk_fetch("wr_br", 16'hFFFE, 1'b0, 16'h0);
        branch_en = 1'b0;
        cyc();
        chk_fetch("wr_top", 16'h0000, 1'b1, wrd(16'hFFFE));
        cyc();
        chk_fetch("wr_zero", 16'h0002, 1'b1, 16'h1111);

        // halt, then debug read from HALT keeps halted high
        cyc();
        chk_fetch("h_f", 16'h0004, 1'b1, 16'h2222);
        cyc();
        chk_fetch("h_op", 16'h0004, 1'b1, 16'hFFFF);
        chk("h_hlt", 16'(halted), 16'h1);
        dbg_req = 1'b1; dbg_addr = 16'h0004;
        cyc();
        chk("hd_hlt", 16'(halted), 16'h1);
        chk("hd_ma", mem_addr, 16'h0004);
        dbg_req = 1'b0;
        cyc();
        chk("hd_ack", 16'(dbg_ack), 16'h1);
        chk("hd_data", dbg_data, 16'hFFFF);
        chk("hd_hlt2", 16'(halted), 16'h1);

        // reset in the middle of a debug read
        start = 1'b1;
        cyc();
        chk("rs_hlt", 16'(halted), 16'h0);
        chk("rs_pc", pc, 16'h0000);
        start = 1'b0; dbg_req = 1'b1; stall = 1'b1; dbg_addr = 16'h0033;
        cyc();
        chk("rd_ma", mem_addr, 16'h0033);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_pc", pc, 16'h0000);
        chk("ra_ins", instr, 16'h0000);
        chk("ra_vld", 16'(instr_valid), 16'h0);
        chk("ra_ack", 16'(dbg_ack), 16'h0);
        chk("ra_data", dbg_data, 16'h0000);
        chk("ra_hlt", 16'(halted), 16'h0);
        dbg_req = 1'b0; stall = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rr%0d_ack", k), 16'(dbg_ack), 16'h0);
            chk($sformatf("rr%0d_pc", k), pc, 16'h0000);
            chk($sformatf("rr%0d_vld", k), 16'(instr_valid), 16'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_fetch_ctrl.md
PROG_FETCH_CTRL -- requirements
Module: prog_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC loaded at reset and on start.
REQ-002 SHALL have parameter HALT_OPCODE, default 16'hFFFF, meaning the instruction word that halts fetch.
REQ-003 SHALL have parameter DBG_MAX_WAIT, default 4, meaning the maximum number of cycles a debug request waits while fetch is active.
REQ-004 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin fetching from RESET_PC.
- stall  in  1  downstream not accepting an instruction this cycle.
- branch_en  in  1  redirect the PC.
- branch_addr  in  16  redirect target.
- dbg_req  in  1  level request for a debug read.
- dbg_addr  in  16  debug byte address.
- mem_addr  out  16  program-memory byte address (combinational).
- mem_data  in  16  program-memory read data, valid in the same cycle.
- instr  out  16  registered instruction.
- instr_valid  out  1  instr is new this cycle.
- pc  out  16  address of the next fetch.
- dbg_ack  out  1  one-cycle pulse; dbg_data is valid.
- dbg_data  out  16  registered debug read data.
- halted  out  1  high in HALT.

Function
REQ-005 SHALL implement states IDLE, FETCH, DBG and HALT; the DBG state SHALL record its return state (FETCH, IDLE or HALT).
REQ-006 mem_addr SHALL equal dbg_addr in DBG, and {pc[15:1],1'b0} in every other state.
REQ-007 IDLE transitions:
- start -> FETCH with pc<=RESET_PC (bit0 cleared).
- dbg_req without start -> DBG.
- start has priority over dbg_req.
REQ-008 FETCH, with no branch, no stall and no debug grant: instr<=mem_data, instr_valid<=1, pc<=pc+2 (modulo 2^16, so 16'hFFFE wraps to 16'h0000).
REQ-009 FETCH with stall and no branch: pc and instr are held, and instr_valid<=0.
REQ-010 FETCH with branch_en: pc<={branch_addr[15:1],1'b0} and instr_valid<=0 (flush); branch_en has priority over stall, debug grant and the halt check.
REQ-011 FETCH, when the fetched mem_data equals HALT_OPCODE under REQ-008 conditions: instr<=HALT_OPCODE, instr_valid<=1, pc is not incremented, next state is HALT.
REQ-012 In FETCH, dbg_req SHALL be granted (next state DBG) when stall is high or when dbg_wait==DBG_MAX_WAIT, and no branch_en is present.
- dbg_wait is a counter that increments each FETCH cycle in which dbg_req is high and not granted.
- dbg_wait clears on grant or when dbg_req is low.
- dbg_wait saturates at DBG_MAX_WAIT.
REQ-013 DBG SHALL last exactly one cycle:
- dbg_data<=mem_data and dbg_ack<=1; the pulse is visible the cycle after DBG.
- pc is held and instr_valid<=0.
- next state is the recorded return state.
REQ-014 A branch_en asserted during DBG SHALL be captured as pending (target latched) and applied on the first FETCH cycle after return, as per REQ-010.
REQ-015 HALT transitions:
- dbg_req -> DBG returning to HALT.
- start -> FETCH with pc<=RESET_PC.
- stall and branch_en are ignored.
- start has priority over dbg_req.
REQ-016 In IDLE and HALT, instr_valid SHALL be 0.
REQ-017 dbg_ack SHALL never be high on two consecutive cycles; a requester holding dbg_req high after an ack receives a new grant no earlier than the next eligible cycle.
REQ-018 halted SHALL be high iff the state is HALT, or the state is DBG with return state HALT.

Reset
REQ-019 While rst_n is low, the block SHALL immediately (asynchronously) force:
- state=IDLE, pc=RESET_PC;
- instr=0, instr_valid=0;
- dbg_data=0, dbg_ack=0;
- dbg_wait=0, pending branch cleared, halted=0.
REQ-020 Reset asserted mid-FETCH or mid-DBG SHALL abort the operation with no dbg_ack produced; after release the block stays in IDLE until start.

Verification
REQ-021 Memory words 0x1111, 0x2222, 0xFFFF at 0x0, 0x2, 0x4; pulse start -> instr_valid for three consecutive cycles with instr 0x1111, 0x2222, 0xFFFF; then halted=1 and pc=0x0004.
REQ-022 FETCH at pc=0x0010 with stall held 3 cycles -> instr_valid=0 and pc=0x0010 throughout; fetch resumes at 0x0010 on release.
REQ-023 branch_en with branch_addr=0x0041 while stall=1 -> pc=0x0040 next cycle, instr_valid=0; next fetch returns mem[0x40].
REQ-024 Continuous fetch with dbg_req high and dbg_addr=0x0033 -> grant after exactly 4 wait cycles; dbg_ack pulses once with dbg_data={mem[0x34],mem[0x33]}; pc unchanged across the DBG cycle.
REQ-025 Fetch reaches pc=0xFFFE -> next pc=0x0000 with no gap in instr_valid.
REQ-026 rst_n dropped during a DBG cycle -> all outputs at reset values immediately; no dbg_ack after release; state=IDLE.
